// File: rtl/bp_pkg.sv
// Shared definitions for the instruction breakpoint unit: FSM state encoding
// and the width helper used for channel-index ports.
package bp_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } bp_state_e;

    // A single-channel unit still exposes a one-bit index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/instr_breakpoint_unit_if.sv
// Bus bundle between the breakpoint unit and its controller: instruction
// stream, configuration writes, run control and status.
interface instr_breakpoint_unit_if
    import bp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_BP = 4,
    parameter int CNT_W  = 8,
    parameter int CYC_W  = 24
);
    localparam int IDX_W = idx_width(NUM_BP);

    logic [WIDTH-1:0]   instruction;
    logic               instr_valid;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [WIDTH-1:0]   cfg_value;
    logic [WIDTH-1:0]   cfg_mask;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_en;
    logic               arm;
    logic               clear;
    logic               halt;
    logic [IDX_W-1:0]   hit_idx;
    logic               timed_out;
    logic [CYC_W-1:0]   cycle_count;
    logic [STATE_W-1:0] state;

    modport master (
        output instruction, instr_valid, cfg_we, cfg_idx, cfg_value, cfg_mask,
               cfg_target, cfg_en, arm, clear,
        input  halt, hit_idx, timed_out, cycle_count, state
    );

    modport slave (
        input  instruction, instr_valid, cfg_we, cfg_idx, cfg_value, cfg_mask,
               cfg_target, cfg_en, arm, clear,
        output halt, hit_idx, timed_out, cycle_count, state
    );

endinterface

// File: rtl/bp_channel.sv
// One breakpoint channel: stored match value/mask/target/enable and a
// saturating hit counter; flags a match and a trigger combinationally.
module bp_channel #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_cfg_we,
    input  logic [WIDTH-1:0] i_cfg_value,
    input  logic [WIDTH-1:0] i_cfg_mask,
    input  logic [CNT_W-1:0] i_cfg_target,
    input  logic             i_cfg_en,
    input  logic             i_clr_cnt,
    input  logic             i_count_en,
    input  logic [WIDTH-1:0] i_instruction,
    input  logic             i_instr_valid,
    output logic             o_match,
    output logic             o_trigger
);
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] r_mask;
    logic [CNT_W-1:0] r_target;
    logic             r_en;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_hits;
    logic [CNT_W-1:0] w_eff_target;

    // A target of zero behaves as one so the first hit always triggers.
    assign w_hits       = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_eff_target = (r_target == {CNT_W{1'b0}}) ? CNT_W'(1) : r_target;
    assign o_match      = r_en & i_instr_valid &
                          (((i_instruction ^ r_value) & r_mask) == {WIDTH{1'b0}});
    assign o_trigger    = i_count_en & o_match & (w_hits >= w_eff_target);

    // Configuration and hit-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value  <= '0;
            r_mask   <= '0;
            r_target <= '0;
            r_en     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_cfg_we) begin
                r_value  <= i_cfg_value;
                r_mask   <= i_cfg_mask;
                r_target <= i_cfg_target;
                r_en     <= i_cfg_en;
            end
            if (i_clr_cnt) begin
                r_cnt <= '0;
            end else if (i_count_en && o_match) begin
                r_cnt <= w_hits;
            end
        end
    end

endmodule

// File: rtl/instr_breakpoint_unit.sv
// Instruction breakpoint unit: run-control FSM, cycle counter, lowest-index
// trigger selection and registered status outputs over NUM_BP channels.
module instr_breakpoint_unit
    import bp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_BP  = 4,
    parameter int CNT_W   = 8,
    parameter int CYC_W   = 24,
    parameter int TIMEOUT = 10000
) (
    input logic               clk,
    input logic               reset,
    instr_breakpoint_unit_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_BP);

    bp_state_e          r_state;
    bp_state_e          w_next;
    logic [CYC_W-1:0]   r_cycle;
    logic               r_halt;
    logic               r_timed_out;
    logic [IDX_W-1:0]   r_hit_idx;

    logic [NUM_BP-1:0]  w_match;
    logic [NUM_BP-1:0]  w_trig;
    logic               w_any;
    logic [IDX_W-1:0]   w_enc;
    logic               w_timeout;
    logic               w_clr_cnt;
    logic               w_count_en;
    logic               w_idle;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_clr_cnt  = bus.clear | (w_idle & bus.arm);
    assign w_count_en = (r_state == ST_ARMED) & ~bus.clear;
    assign w_any      = |w_trig;
    assign w_timeout  = (TIMEOUT != 0) && (r_cycle == CYC_W'(TIMEOUT - 1));

    for (genvar g = 0; g < NUM_BP; g++) begin : g_ch
        bp_channel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_cfg_we     (bus.cfg_we & w_idle & (bus.cfg_idx == IDX_W'(g))),
            .i_cfg_value  (bus.cfg_value),
            .i_cfg_mask   (bus.cfg_mask),
            .i_cfg_target (bus.cfg_target),
            .i_cfg_en     (bus.cfg_en),
            .i_clr_cnt    (w_clr_cnt),
            .i_count_en   (w_count_en),
            .i_instruction(bus.instruction),
            .i_instr_valid(bus.instr_valid),
            .o_match      (w_match[g]),
            .o_trigger    (w_trig[g])
        );
    end

    // Lowest-indexed triggering channel wins.
    always_comb begin
        w_enc = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_trig[i]) begin
                w_enc = IDX_W'(i);
            end else begin
                w_enc = w_enc;
            end
        end
    end

    // Next-state logic; clear overrides everything, trigger beats timeout.
    always_comb begin
        w_next = r_state;
        if (bus.clear) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.arm) begin
                        w_next = ST_ARMED;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (w_any) begin
                        w_next = ST_HALTED;
                    end else if (w_timeout) begin
                        w_next = ST_TIMEOUT;
                    end else begin
                        w_next = ST_ARMED;
                    end
                end
                ST_HALTED:  w_next = ST_HALTED;
                ST_TIMEOUT: w_next = ST_TIMEOUT;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    // State, cycle counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cycle     <= '0;
            r_halt      <= 1'b0;
            r_timed_out <= 1'b0;
            r_hit_idx   <= '0;
        end else begin
            r_state     <= w_next;
            r_halt      <= (w_next == ST_HALTED);
            r_timed_out <= (w_next == ST_TIMEOUT);
            if (w_next != ST_HALTED) begin
                r_hit_idx <= '0;
            end else if (r_state != ST_HALTED) begin
                r_hit_idx <= w_enc;
            end
            if (w_clr_cnt) begin
                r_cycle <= '0;
            end else if (r_state == ST_ARMED && r_cycle != {CYC_W{1'b1}}) begin
                r_cycle <= r_cycle + CYC_W'(1);
            end
        end
    end

    assign bus.state       = r_state;
    assign bus.halt        = r_halt;
    assign bus.timed_out   = r_timed_out;
    assign bus.hit_idx     = r_hit_idx;
    assign bus.cycle_count = r_cycle;

    logic w_unused;
    assign w_unused = ^w_match;

endmodule
